// File: rtl/pcie_mailbox_slave.sv
// BAR0 mailbox: Avalon-MM slave with control/status/sticky-error registers, a TX FIFO to the datapath
// and an RX FIFO drained by host reads. Optional level interrupt enabled by defining PCIE_MAILBOX_IRQ_EN.
module pcie_mailbox_slave #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] ID_VALUE   = 32'h3DE5_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        avs_waitrequest,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef PCIE_MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_TXDATA = 3'd2;
    localparam logic [2:0] ADDR_RXDATA = 3'd3;
    localparam logic [2:0] ADDR_CLEAR  = 3'd4;
    localparam logic [2:0] ADDR_ID     = 3'd5;

    logic [31:0]   tx_mem [FIFO_DEPTH];
    logic [31:0]   rx_mem [FIFO_DEPTH];

    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic          enable_q, enable_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          readdatavalid_q, readdatavalid_d;
    logic          irq_en;

    logic wr_en, rd_en, ctrl_wr, clear_wr;
    logic tx_flush, rx_flush;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push_req, tx_push, tx_pop;
    logic rx_pop_req, rx_pop, rx_push;
    logic [31:0] status_word;

    // A simultaneous read and write is treated as a write only.
    assign wr_en       = avs_write;
    assign rd_en       = avs_read & ~avs_write;
    assign ctrl_wr     = wr_en & (avs_address == ADDR_CTRL);
    assign clear_wr    = wr_en & (avs_address == ADDR_CLEAR);
    assign tx_flush    = ctrl_wr & avs_writedata[1];
    assign rx_flush    = ctrl_wr & avs_writedata[2];

    assign tx_full     = (tx_count_q == DEPTH_C);
    assign tx_empty    = (tx_count_q == '0);
    assign rx_full     = (rx_count_q == DEPTH_C);
    assign rx_empty    = (rx_count_q == '0);

    assign tx_valid    = enable_q & ~tx_empty;
    assign rx_ready    = enable_q & ~rx_full;
    assign tx_data     = tx_mem[tx_rd_ptr_q];

    // Full/empty come from registered counts, so a same-cycle pop never frees room for a push.
    assign tx_push_req = wr_en & (avs_address == ADDR_TXDATA);
    assign tx_push     = tx_push_req & ~tx_full & ~tx_flush;
    assign tx_pop      = tx_valid & tx_ready & ~tx_flush;
    assign rx_pop_req  = rd_en & (avs_address == ADDR_RXDATA);
    assign rx_pop      = rx_pop_req & ~rx_empty & ~rx_flush;
    assign rx_push     = rx_valid & rx_ready & ~rx_flush;

    assign status_word = {12'd0, underflow_q, overflow_q, rx_empty, tx_full,
                          8'(rx_count_q), 8'(tx_count_q)};

    assign avs_waitrequest   = 1'b0;
    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q] <= avs_writedata;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_q] <= rx_data;
        end
    end

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (tx_flush) begin
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_count_d  = '0;
        end else begin
            if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
            if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
            if (tx_push && !tx_pop)      tx_count_d = tx_count_q + CNT_ONE;
            else if (!tx_push && tx_pop) tx_count_d = tx_count_q - CNT_ONE;
        end
    end

    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        if (rx_flush) begin
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_count_d  = '0;
        end else begin
            if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
            if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
            if (rx_push && !rx_pop)      rx_count_d = rx_count_q + CNT_ONE;
            else if (!rx_push && rx_pop) rx_count_d = rx_count_q - CNT_ONE;
        end
    end

    // Sticky errors: a same-cycle set beats the CLEAR write.
    always_comb begin
        enable_d    = ctrl_wr ? avs_writedata[0] : enable_q;
        overflow_d  = (tx_push_req & tx_full) |
                      (overflow_q & ~(clear_wr & avs_writedata[0]));
        underflow_d = (rx_pop_req & rx_empty) |
                      (underflow_q & ~(clear_wr & avs_writedata[1]));
    end

    always_comb begin
        readdatavalid_d = rd_en;
        readdata_d      = '0;
        if (rd_en) begin
            case (avs_address)
                ADDR_CTRL:   readdata_d = {28'd0, irq_en, 2'b00, enable_q};
                ADDR_STATUS: readdata_d = status_word;
                ADDR_RXDATA: readdata_d = rx_empty ? 32'd0 : rx_mem[rx_rd_ptr_q];
                ADDR_ID:     readdata_d = ID_VALUE;
                default:     readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_ptr_q     <= '0;
            tx_rd_ptr_q     <= '0;
            tx_count_q      <= '0;
            rx_wr_ptr_q     <= '0;
            rx_rd_ptr_q     <= '0;
            rx_count_q      <= '0;
            enable_q        <= 1'b0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            tx_wr_ptr_q     <= tx_wr_ptr_d;
            tx_rd_ptr_q     <= tx_rd_ptr_d;
            tx_count_q      <= tx_count_d;
            rx_wr_ptr_q     <= rx_wr_ptr_d;
            rx_rd_ptr_q     <= rx_rd_ptr_d;
            rx_count_q      <= rx_count_d;
            enable_q        <= enable_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

`ifdef PCIE_MAILBOX_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;

    assign irq_en = irq_en_q;
    assign irq    = irq_q;

    always_comb begin
        irq_en_d = ctrl_wr ? avs_writedata[3] : irq_en_q;
        irq_d    = irq_en_q & ((rx_count_q != '0) | overflow_q | underflow_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_mailbox_slave.sv
// Bench for pcie_mailbox_slave: directed scenarios plus random traffic checked every cycle
// against a queue-based model of the register map and both FIFOs.
module tb_pcie_mailbox_slave;

    localparam int          DEPTH = 8;
    localparam logic [31:0] ID    = 32'h3DE5_0001;

    logic        clk;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
`ifdef PCIE_MAILBOX_IRQ_EN
    logic        irq;
`endif

    pcie_mailbox_slave #(.FIFO_DEPTH(DEPTH), .ID_VALUE(ID)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready)
`ifdef PCIE_MAILBOX_IRQ_EN
        ,
        .irq               (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    bit          m_en, m_irq_en, m_ov, m_un, m_rdv, m_irq;
    logic [31:0] m_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {12'd0, m_un, m_ov, (rx_q.size() == 0), (tx_q.size() == DEPTH),
                8'(rx_q.size()), 8'(tx_q.size())};
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_en = 0; m_irq_en = 0; m_ov = 0; m_un = 0; m_rdv = 0; m_irq = 0; m_rdata = '0;
    endtask

    // Entered at posedge+1: checks outputs at the falling edge, advances the model across the next rising edge.
    task automatic tick();
        bit          wr, rd, tv, rr, tpop, tpush_ok, ovs, rpush, rpop_ok, uns, tfl, rfl, cwr;
        bit [1:0]    clr;
        bit          nx_rdv, nx_irq;
        logic [31:0] nx_rdata, wd, rxd;
        #4;
        tv = m_en && (tx_q.size() > 0);
        rr = m_en && (rx_q.size() < DEPTH);
        check_eq("waitrequest", avs_waitrequest, 0);
        check_eq("tx_valid", tx_valid, tv);
        if (tv) check_eq("tx_data", tx_data, tx_q[0]);
        check_eq("rx_ready", rx_ready, rr);
        check_eq("readdatavalid", avs_readdatavalid, m_rdv);
        if (m_rdv) check_eq("readdata", avs_readdata, m_rdata);
`ifdef PCIE_MAILBOX_IRQ_EN
        check_eq("irq", irq, m_irq);
`endif
        wr  = avs_write;
        rd  = avs_read && !avs_write;
        wd  = avs_writedata;
        rxd = rx_data;
        nx_rdv   = rd;
        nx_rdata = '0;
        if (rd) begin
            case (avs_address)
                3'd0:    nx_rdata = {28'd0, m_irq_en, 2'b00, m_en};
                3'd1:    nx_rdata = m_status();
                3'd3:    nx_rdata = (rx_q.size() > 0) ? rx_q[0] : 32'd0;
                3'd5:    nx_rdata = ID;
                default: nx_rdata = '0;
            endcase
        end
        nx_irq   = m_irq_en && (rx_q.size() != 0 || m_ov || m_un);
        cwr      = wr && avs_address == 3'd0;
        tfl      = cwr && wd[1];
        rfl      = cwr && wd[2];
        tpop     = tv && tx_ready;
        tpush_ok = wr && avs_address == 3'd2 && tx_q.size() < DEPTH;
        ovs      = wr && avs_address == 3'd2 && tx_q.size() == DEPTH;
        rpush    = rx_valid && rr;
        rpop_ok  = rd && avs_address == 3'd3 && rx_q.size() > 0;
        uns      = rd && avs_address == 3'd3 && rx_q.size() == 0;
        clr      = (wr && avs_address == 3'd4) ? wd[1:0] : 2'b00;
        @(posedge clk);
        #1;
        if (tfl) tx_q.delete();
        else begin
            if (tpop) void'(tx_q.pop_front());
            if (tpush_ok) tx_q.push_back(wd);
        end
        if (rfl) rx_q.delete();
        else begin
            if (rpop_ok) void'(rx_q.pop_front());
            if (rpush) rx_q.push_back(rxd);
        end
        m_ov = ovs || (m_ov && !clr[0]);
        m_un = uns || (m_un && !clr[1]);
        if (cwr) begin
            m_en = wd[0];
`ifdef PCIE_MAILBOX_IRQ_EN
            m_irq_en = wd[3];
`endif
        end
        m_rdv   = nx_rdv;
        m_rdata = nx_rdata;
        m_irq   = nx_irq;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1; avs_read = 0;
        tick();
        avs_write = 0;
    endtask

    task automatic host_read(input logic [2:0] a);
        avs_address = a; avs_read = 1; avs_write = 0;
        tick();
        avs_read = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int wa[8] = '{2, 2, 2, 0, 4, 6, 2, 7};
        int ra[10] = '{3, 3, 3, 1, 1, 0, 5, 2, 4, 6};
        reset_n = 0; avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
        tx_ready = 0; rx_data = '0; rx_valid = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_readdata", avs_readdata, 0);
        check_eq("rst_rdvalid", avs_readdatavalid, 0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_rx_ready", rx_ready, 0);
`ifdef PCIE_MAILBOX_IRQ_EN
        check_eq("rst_irq", irq, 0);
`endif
        reset_n = 1;

        // ID and reset STATUS
        host_read(3'd5);
        check_eq("id_rdvalid", avs_readdatavalid, 1);
        check_eq("id_value", avs_readdata, 32'h3DE5_0001);
        host_read(3'd1);
        check_eq("status_reset", avs_readdata, 32'h0002_0000);

        // TX overflow then ordered streaming
        host_write(3'd0, 32'h1);
        for (int k = 0; k < 9; k++) host_write(3'd2, 32'h100 + k);
        host_read(3'd1);
        check_eq("status_tx_full", avs_readdata, 32'h0007_0008);
        tx_ready = 1;
        for (int k = 0; k < 8; k++) begin
            check_eq("stream_valid", tx_valid, 1);
            check_eq("stream_data", tx_data, 32'h100 + k);
            tick();
        end
        check_eq("stream_done", tx_valid, 0);
        tx_ready = 0;
        host_write(3'd4, 32'h1);

        // RX fill, drain past empty, underflow clear
        rx_valid = 1;
        for (int k = 0; k < 3; k++) begin
            rx_data = 32'hA0 + k;
            tick();
        end
        rx_valid = 0;
        for (int k = 0; k < 4; k++) begin
            host_read(3'd3);
            check_eq("rx_drain", avs_readdata, (k < 3) ? 32'hA0 + k : 32'h0);
        end
        host_read(3'd1);
        check_eq("underflow_set", avs_readdata, 32'h000A_0000);
        host_write(3'd4, 32'h2);
        host_read(3'd1);
        check_eq("underflow_clr", avs_readdata, 32'h0002_0000);

        // Both full, then flush both
        for (int k = 0; k < DEPTH; k++) host_write(3'd2, $urandom);
        rx_valid = 1;
        for (int k = 0; k < DEPTH; k++) begin
            rx_data = $urandom;
            tick();
        end
        rx_valid = 0;
        host_read(3'd1);
        check_eq("both_full_counts", avs_readdata[15:0], 16'h0808);
        host_write(3'd0, 32'h7);
        check_eq("flush_tx_valid", tx_valid, 0);
        check_eq("flush_rx_ready", rx_ready, 1);
        host_read(3'd1);
        check_eq("flush_status", avs_readdata, 32'h0002_0000);

        // Full TX with same-cycle pop and push: push still dropped
        for (int k = 0; k < DEPTH; k++) host_write(3'd2, 32'h200 + k);
        tx_ready = 1;
        host_write(3'd2, 32'hDEAD_BEEF);
        tx_ready = 0;
        host_read(3'd1);
        check_eq("full_pop_count", avs_readdata[7:0], 8'd7);
        check_eq("full_pop_ovf", avs_readdata[18], 1);
        host_write(3'd0, 32'h3);
        host_write(3'd4, 32'h3);

        // RX push and pop in the same cycle
        rx_valid = 1;
        for (int k = 0; k < 2; k++) begin
            rx_data = 32'h300 + k;
            tick();
        end
        rx_data = 32'h302;
        host_read(3'd3);
        rx_valid = 0;
        check_eq("rx_pushpop_data", avs_readdata, 32'h300);
        host_read(3'd1);
        check_eq("rx_pushpop_count", avs_readdata[15:8], 8'd2);
        host_write(3'd0, 32'h7);

        // CTRL bit3 and interrupt timing
        host_write(3'd0, 32'h9);
        host_read(3'd0);
`ifdef PCIE_MAILBOX_IRQ_EN
        check_eq("ctrl_irq_en", avs_readdata, 32'h9);
        rx_valid = 1; rx_data = 32'h77;
        tick();
        rx_valid = 0;
        check_eq("irq_lag_rise", irq, 0);
        tick();
        check_eq("irq_rise", irq, 1);
        host_read(3'd3);
        check_eq("irq_lag_fall", irq, 1);
        tick();
        check_eq("irq_fall", irq, 0);
`else
        check_eq("ctrl_no_irq_en", avs_readdata, 32'h1);
`endif
        host_write(3'd0, 32'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            avs_read = 0; avs_write = 0;
            avs_writedata = $urandom;
            if (r >= 40 && r < 70) begin
                avs_write = 1;
                avs_address = 3'(wa[$urandom_range(0, 7)]);
            end else if (r >= 70 && r < 97) begin
                avs_read = 1;
                avs_address = 3'(ra[$urandom_range(0, 9)]);
            end else if (r >= 97) begin
                avs_read = 1; avs_write = 1;
                avs_address = 3'(wa[$urandom_range(0, 7)]);
            end
            if (avs_write && avs_address == 3'd0) begin
                avs_writedata[0] = ($urandom_range(0, 9) != 0);
                avs_writedata[1] = ($urandom_range(0, 19) == 0);
                avs_writedata[2] = ($urandom_range(0, 19) == 0);
            end
            tx_ready = ($urandom_range(0, 1) == 1);
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_data  = $urandom;
            tick();
        end
        avs_read = 0; avs_write = 0; rx_valid = 0; tx_ready = 0;

        // Reset in the middle of a read
        host_write(3'd2, 32'h4444);
        host_read(3'd5);
        #2;
        reset_n = 0;
        #1;
        check_eq("mid_rst_rdvalid", avs_readdatavalid, 0);
        check_eq("mid_rst_readdata", avs_readdata, 0);
        check_eq("mid_rst_tx_valid", tx_valid, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1;
        repeat (3) tick();
        host_read(3'd1);
        check_eq("post_rst_status", avs_readdata, 32'h0002_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
